// File: rtl/slow_mem_responder.sv
// slow_mem_responder
// Memory-side responder for the cache line interface. Accepts one 128-bit
// line read or write at a time, waits LATENCY cycles, then answers with a
// single-cycle mem_ready pulse (read data valid on that pulse). Backs a store
// of 2**DEPTH_LOG2 lines; higher address bits alias. Simultaneous read+write
// requests are rejected and latch the sticky proto_err flag.
//
// Optional feature: define SLOW_MEM_STATS_EN to add saturating 16-bit
// rd_count / wr_count ports counting completed reads and writes.
module slow_mem_responder #(
   parameter int LATENCY    = 10,
   parameter int DEPTH_LOG2 = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         mem_read,
   input  logic         mem_write,
   input  logic [27:0]  mem_addr,
   input  logic [127:0] mem_wdata,
   output logic [127:0] mem_rdata,
   output logic         mem_ready,
   output logic         proto_err
`ifdef SLOW_MEM_STATS_EN
   ,
   output logic [15:0]  rd_count,
   output logic [15:0]  wr_count
`endif
);

   localparam int CNT_W = $clog2(LATENCY + 1);
   localparam int DEPTH = 1 << DEPTH_LOG2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BUSY  = 2'd1,
      READY = 2'd2
   } state_t;

   state_t                  state_reg, state_next;
   logic [CNT_W-1:0]        cnt_reg, cnt_next;
   logic                    op_write_reg, op_write_next;
   logic [DEPTH_LOG2-1:0]   idx_reg, idx_next;
   logic [127:0]            wdata_reg, wdata_next;
   logic [127:0]            rdata_reg;
   logic                    ready_reg, ready_next;
   logic                    proto_err_reg, proto_err_next;
   // High during the last BUSY cycle: the coming edge performs the access.
   logic                    commit;

   logic [127:0]            mem_array [DEPTH];

   assign mem_rdata = rdata_reg;
   assign mem_ready = ready_reg;
   assign proto_err = proto_err_reg;

   // Next-state and transaction-latch logic; request inputs only matter in IDLE.
   always_comb begin
      state_next     = state_reg;
      cnt_next       = cnt_reg;
      op_write_next  = op_write_reg;
      idx_next       = idx_reg;
      wdata_next     = wdata_reg;
      ready_next     = 1'b0;
      proto_err_next = proto_err_reg;
      commit         = 1'b0;
      case (state_reg)
         IDLE: begin
            if (mem_read && mem_write) begin
               proto_err_next = 1'b1;
            end else if (mem_read || mem_write) begin
               op_write_next = mem_write;
               idx_next      = mem_addr[DEPTH_LOG2-1:0];
               wdata_next    = mem_wdata;
               cnt_next      = CNT_W'(LATENCY);
               state_next    = BUSY;
            end
         end
         BUSY: begin
            if (cnt_reg == CNT_W'(1)) begin
               commit     = 1'b1;
               ready_next = 1'b1;
               cnt_next   = '0;
               state_next = READY;
            end else begin
               cnt_next = cnt_reg - CNT_W'(1);
            end
         end
         READY: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Control and output registers; reset returns to IDLE and drops any in-flight access.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         cnt_reg       <= '0;
         op_write_reg  <= 1'b0;
         idx_reg       <= '0;
         wdata_reg     <= '0;
         rdata_reg     <= '0;
         ready_reg     <= 1'b0;
         proto_err_reg <= 1'b0;
      end else begin
         state_reg     <= state_next;
         cnt_reg       <= cnt_next;
         op_write_reg  <= op_write_next;
         idx_reg       <= idx_next;
         wdata_reg     <= wdata_next;
         ready_reg     <= ready_next;
         proto_err_reg <= proto_err_next;
         if (commit && !op_write_reg) begin
            rdata_reg <= mem_array[idx_reg];
         end
      end
   end

   // Line store write port; commit is never high while reset holds the FSM in IDLE.
   always_ff @(posedge clk) begin
      if (commit && op_write_reg) begin
         mem_array[idx_reg] <= wdata_reg;
      end
   end

`ifdef SLOW_MEM_STATS_EN
   // Index 0 counts reads, index 1 counts writes.
   genvar gi;
   for (gi = 0; gi < 2; gi++) begin : g_stat
      logic        hit;
      logic [15:0] cnt_reg;
      assign hit = commit && ((gi == 1) ? op_write_reg : !op_write_reg);
      // Saturating completion counter, bumped on the edge mem_ready rises.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            cnt_reg <= '0;
         end else if (hit && (cnt_reg != 16'hFFFF)) begin
            cnt_reg <= cnt_reg + 16'd1;
         end
      end
   end
   assign rd_count = g_stat[0].cnt_reg;
   assign wr_count = g_stat[1].cnt_reg;
`endif

endmodule

// File: tb/tb_slow_mem_responder.sv
// tb_slow_mem_responder
// Directed test with a scoreboard: each issued request pushes its expected
// completion (cycle and read data) into a queue, and an independent monitor
// pops and checks it whenever mem_ready is seen.
module tb_slow_mem_responder;

   localparam int LAT = 4;
   localparam int DL2 = 8;

   logic         clk;
   logic         rst_n;
   logic         mem_read;
   logic         mem_write;
   logic [27:0]  mem_addr;
   logic [127:0] mem_wdata;
   logic [127:0] mem_rdata;
   logic         mem_ready;
   logic         proto_err;
`ifdef SLOW_MEM_STATS_EN
   logic [15:0]  rd_count;
   logic [15:0]  wr_count;
`endif

   slow_mem_responder #(.LATENCY(LAT), .DEPTH_LOG2(DL2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .mem_read  (mem_read),
      .mem_write (mem_write),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ready (mem_ready),
      .proto_err (proto_err)
`ifdef SLOW_MEM_STATS_EN
      ,
      .rd_count  (rd_count),
      .wr_count  (wr_count)
`endif
   );

   typedef struct {
      string        name;
      logic [127:0] rdata;
      int           cyc;
   } exp_t;

   exp_t         sb_q[$];
   int           n_vec = 0;
   int           n_err = 0;
   int           cyc = 0;
   logic [127:0] model_rdata = '0;
   int           exp_rd = 0;
   int           exp_wr = 0;
   logic         prev_ready = 1'b0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   // Monitor: pops one expectation per ready pulse and checks timing, data and pulse width.
   always @(negedge clk) begin
      if (rst_n && mem_ready) begin
         if (prev_ready) begin
            n_vec++; n_err++;
            $display("FAIL ready_width: mem_ready high two cycles in a row at cycle %0d", cyc);
         end else if (sb_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL unexpected_ready: mem_ready with no request outstanding at cycle %0d", cyc);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            $display("txn %s done cycle %0d rdata %h", e.name, cyc, mem_rdata);
            check({e.name, "_cycle"}, 128'(cyc), 128'(e.cyc));
            check({e.name, "_rdata"}, mem_rdata, e.rdata);
         end
      end
      prev_ready = rst_n && mem_ready;
   end

   // Issue one request at the next negedge, hold it until ready, then drop it.
   // glitch>0: that many cycles into BUSY, scramble address/data and drop the request.
   task automatic do_req(input string name, input logic rd, input logic [27:0] addr,
                         input logic [127:0] wdata, input logic [127:0] exp_rdata,
                         input int glitch);
      exp_t e;
      bit   seen = 0;
      @(negedge clk);
      mem_read  = rd;
      mem_write = !rd;
      mem_addr  = addr;
      mem_wdata = wdata;
      if (rd) model_rdata = exp_rdata;
      e.name  = name;
      e.rdata = model_rdata;
      e.cyc   = cyc + 1 + LAT;
      sb_q.push_back(e);
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         if (glitch > 0 && i == glitch - 1) begin
            mem_addr  = addr ^ 28'h1;
            mem_wdata = ~wdata;
            mem_write = 1'b0;
            mem_read  = 1'b0;
         end
         if (mem_ready) seen = 1;
      end
      if (!seen) begin
         n_vec++; n_err++;
         $display("FAIL %s_timeout: mem_ready 0, required 1 within 40 cycles", name);
      end else if (rd) begin
         exp_rd++;
      end else begin
         exp_wr++;
      end
      mem_read  = 1'b0;
      mem_write = 1'b0;
   endtask

   task automatic do_dual(input logic [27:0] addr);
      @(negedge clk);
      mem_read  = 1'b1;
      mem_write = 1'b1;
      mem_addr  = addr;
      @(negedge clk);
      mem_read  = 1'b0;
      mem_write = 1'b0;
      $display("txn dual addr %h proto_err %b", addr, proto_err);
      check("dual_proto_err", 128'(proto_err), 128'(1));
   endtask

   initial begin
      rst_n     = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      repeat (2) @(negedge clk);
      check("rst_ready", 128'(mem_ready), 128'(0));
      check("rst_rdata", mem_rdata, 128'(0));
      check("rst_proto_err", 128'(proto_err), 128'(0));
      rst_n = 1'b1;

      // Basic write then read.
      do_req("wr_10", 1'b0, 28'h0000010, 128'hDEADBEEF, '0, 0);
      do_req("rd_10", 1'b1, 28'h0000010, '0, 128'hDEADBEEF, 0);

      // Aliasing modulo 256 lines.
      do_req("wr_05", 1'b0, 28'h0000005, 128'hAAAA_0001, '0, 0);
      do_req("wr_105", 1'b0, 28'h0000105, 128'hBBBB_0002, '0, 0);
      do_req("rd_05", 1'b1, 28'h0000005, '0, 128'hBBBB_0002, 0);

      // Dual request: sticky error, no response; later legal read still works.
      do_dual(28'h0000010);
      repeat (LAT + 3) @(negedge clk);
      check("dual_sticky", 128'(proto_err), 128'(1));
      do_req("rd_10_b", 1'b1, 28'h0000010, '0, 128'hDEADBEEF, 0);
      check("proto_err_kept", 128'(proto_err), 128'(1));

      // Inputs scrambled mid-BUSY: latched transaction wins.
      do_req("wr_21", 1'b0, 28'h0000021, 128'h2121, '0, 0);
      do_req("wr_20_glitch", 1'b0, 28'h0000020, 128'h2020, '0, 2);
      do_req("rd_20", 1'b1, 28'h0000020, '0, 128'h2020, 0);
      do_req("rd_21", 1'b1, 28'h0000021, '0, 128'h2121, 0);

      // Reset one cycle before a write's commit edge.
      do_req("wr_30", 1'b0, 28'h0000030, 128'h3333, '0, 0);
      @(negedge clk);
      mem_write = 1'b1;
      mem_addr  = 28'h0000030;
      mem_wdata = 128'h4444;
      repeat (LAT) @(negedge clk);
      rst_n     = 1'b0;
      mem_write = 1'b0;
      @(negedge clk);
      $display("txn reset_mid_write ready %b rdata %h proto_err %b", mem_ready, mem_rdata, proto_err);
      check("rst_mid_ready", 128'(mem_ready), 128'(0));
      check("rst_mid_rdata", mem_rdata, 128'(0));
      check("rst_mid_proto_err", 128'(proto_err), 128'(0));
      rst_n       = 1'b1;
      model_rdata = '0;
      exp_rd      = 0;
      exp_wr      = 0;

      // Post-reset traffic, back to back at LATENCY+2.
      do_req("rd_30", 1'b1, 28'h0000030, '0, 128'h3333, 0);
      do_req("rd_05_b", 1'b1, 28'h0000005, '0, 128'hBBBB_0002, 0);
      do_req("wr_40", 1'b0, 28'h0000040, 128'h4040_4040, '0, 0);
      do_req("wr_41", 1'b0, 28'h0000041, 128'h4141_4141, '0, 0);
      do_req("rd_40", 1'b1, 28'h0000040, '0, 128'h4040_4040, 0);
      do_dual(28'h0000041);
      repeat (LAT + 3) @(negedge clk);
`ifdef SLOW_MEM_STATS_EN
      $display("txn stats rd_count %0d wr_count %0d", rd_count, wr_count);
      check("rd_count", 128'(rd_count), 128'(3));
      check("wr_count", 128'(wr_count), 128'(2));
`endif
      check("tb_counts", 128'(exp_rd * 16 + exp_wr), 128'(3 * 16 + 2));
      check("sb_empty", 128'(sb_q.size()), 128'(0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
